// File: rtl/sig_gen_pkg.sv
// Shared types and default constants for the multi-channel signal generator.
package sig_gen_pkg;

  localparam int DEF_NUM_CH     = 8;
  localparam int DEF_WIN_CYCLES = 96000000;
  localparam int DEF_CNT_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : sig_gen_pkg

// File: rtl/sig_gen_if.sv
// Configuration, window control and generated-signal bundle of sig_gen.
interface sig_gen_if
  import sig_gen_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [2:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_we;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] pulse_out;
  logic [CNT_W-1:0]  edge_cnt;

  modport master (
    output cfg_ch, cfg_period, cfg_we, start, stop,
    input  busy, done, pulse_out, edge_cnt
  );

  modport slave (
    input  cfg_ch, cfg_period, cfg_we, start, stop,
    output busy, done, pulse_out, edge_cnt
  );

endinterface : sig_gen_if

// File: rtl/sig_gen_chan.sv
// One generator channel: period register, phase counter, output register and,
// when SIG_GEN_EDGECNT_EN is defined, the rising-edge counter with its latch.
module sig_gen_chan
  import sig_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             launch,
  input  logic             active,
  input  logic             run,
`ifdef SIG_GEN_EDGECNT_EN
  input  logic             finish,
  output logic [CNT_W-1:0] edge_latch,
`endif
  output logic             pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] phase_r;
  logic             pulse_r;
  logic             valid_s;
  logic             wrap_s;
  logic [CNT_W-1:0] half_s;

  assign valid_s = (period_r >= CNT_TWO);
  assign wrap_s  = (phase_r == (period_r - CNT_ONE));
  assign half_s  = period_r >> 1;

  // Period register, phase counter and registered output level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_r <= '0;
      phase_r  <= '0;
      pulse_r  <= 1'b0;
    end else begin
      if (cfg_we) begin
        period_r <= cfg_period;
      end
      // Degenerate periods park the phase at zero so it never runs away.
      if (launch || !valid_s) begin
        phase_r <= '0;
      end else if (active) begin
        phase_r <= wrap_s ? '0 : (phase_r + CNT_ONE);
      end
      pulse_r <= run && valid_s && (phase_r < half_s);
    end
  end

  assign pulse = pulse_r;

`ifdef SIG_GEN_EDGECNT_EN
  logic             rise_s;
  logic [CNT_W-1:0] edge_r;
  logic [CNT_W-1:0] latch_r;

  // A rise is emitted for every phase-zero cycle of the window, including the
  // final one whose high level is cut off by the window end.
  assign rise_s = active && valid_s && (phase_r == '0);

  // Edge counter and end-of-window latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_r  <= '0;
      latch_r <= '0;
    end else begin
      if (launch) begin
        edge_r <= '0;
      end else if (rise_s) begin
        edge_r <= edge_r + CNT_ONE;
      end
      if (finish) begin
        latch_r <= edge_r + (rise_s ? CNT_ONE : '0);
      end
    end
  end

  assign edge_latch = latch_r;
`endif

endmodule : sig_gen_chan

// File: rtl/sig_gen.sv
// Windowed multi-channel square-wave generator with IDLE/RUN/DONE control.
// Define SIG_GEN_EDGECNT_EN to build the per-channel edge counters.
module sig_gen
  import sig_gen_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int WIN_CYCLES = DEF_WIN_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     rst,
  sig_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_r;
  state_e            state_s;
  logic [CNT_W-1:0]  win_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              idle_s;
  logic              active_s;
  logic              launch_s;
  logic              run_s;
  logic [NUM_CH-1:0] pulse_s;

  // Window FSM next state; stop has priority over start and window end.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.stop) begin
          state_s = ST_IDLE;
        end else if (bus.start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_s = ST_IDLE;
        end else if (win_cnt_r == WIN_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign idle_s   = (state_r == ST_IDLE);
  assign active_s = (state_r == ST_RUN);
  assign launch_s = idle_s && (state_s == ST_RUN);
  // Channel outputs only stay live while the window continues.
  assign run_s    = active_s && (state_s == ST_RUN);

  // FSM state, window counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      win_cnt_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
      if (launch_s) begin
        win_cnt_r <= '0;
      end else if (active_s) begin
        win_cnt_r <= win_cnt_r + CNT_ONE;
      end
    end
  end

`ifdef SIG_GEN_EDGECNT_EN
  logic             finish_s;
  logic [CNT_W-1:0] latch_s [NUM_CH];
  logic [CNT_W-1:0] edge_cnt_s;

  assign finish_s = active_s && (state_s == ST_DONE);
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    logic we_s;

    assign we_s = bus.cfg_we && idle_s && (int'(bus.cfg_ch) == g);

    sig_gen_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (we_s),
      .cfg_period(bus.cfg_period),
      .launch    (launch_s),
      .active    (active_s),
      .run       (run_s),
`ifdef SIG_GEN_EDGECNT_EN
      .finish    (finish_s),
      .edge_latch(latch_s[g]),
`endif
      .pulse     (pulse_s[g])
    );
  end

`ifdef SIG_GEN_EDGECNT_EN
  // Read mux of latched counts; unpopulated channel numbers read as zero.
  always_comb begin
    edge_cnt_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      edge_cnt_s = edge_cnt_s | ((int'(bus.cfg_ch) == i) ? latch_s[i] : '0);
    end
  end

  assign bus.edge_cnt = edge_cnt_s;
`else
  assign bus.edge_cnt = '0;
`endif

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pulse_out = pulse_s;

endmodule : sig_gen

// File: tb/tb_sig_gen.sv
// Randomized self-checking bench for sig_gen with a 1000-cycle window.
module tb_sig_gen;
  import sig_gen_pkg::*;

  localparam int NCH = 8;
  localparam int W   = 1000;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic rst;

  sig_gen_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  sig_gen #(
    .NUM_CH    (NCH),
    .WIN_CYCLES(W),
    .CNT_W     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_per  [NCH];
  int exp_edge [NCH];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: channel level at window cycle k (k>=1) follows phase k-1.
  function automatic logic [NCH-1:0] exp_pulse(input int k);
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      if (exp_per[c] >= 2 && ((k - 1) % exp_per[c]) < (exp_per[c] / 2)) v[c] = 1'b1;
    end
    return v;
  endfunction

  function automatic int edges_for(input int p);
`ifdef SIG_GEN_EDGECNT_EN
    return (p >= 2) ? (W + p - 1) / p : 0;
`else
    return (p >= 0) ? 0 : 0;
`endif
  endfunction

  task automatic cfg_write(input int ch, input int p);
    bus.cfg_ch     = 3'(ch);
    bus.cfg_period = CW'(p);
    bus.cfg_we     = 1'b1;
    tick();
    bus.cfg_we     = 1'b0;
    exp_per[ch]    = p;
  endtask

  task automatic check_edges();
    for (int c = 0; c < NCH; c++) begin
      bus.cfg_ch = 3'(c);
      tick();
      check_val($sformatf("edge_cnt_ch%0d", c), bus.edge_cnt, exp_edge[c]);
    end
  endtask

  // stop_at < 0 runs the full window; poke issues cfg_we and start mid-window.
  task automatic run_window(input int stop_at, input bit poke);
    bit stopped;
    stopped   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("busy_entry", bus.busy, 1);
    check_val("pulse_entry", bus.pulse_out, 0);
    for (int k = 1; k < W; k++) begin
      if (k - 1 == stop_at) bus.stop = 1'b1;
      if (poke && k - 1 == 300) begin
        bus.cfg_ch     = 3'd0;
        bus.cfg_period = 32'd10;
        bus.cfg_we     = 1'b1;
        bus.start      = 1'b1;
      end
      tick();
      bus.stop   = 1'b0;
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;
      if (k - 1 == stop_at) begin
        stopped = 1'b1;
        check_val("busy_after_stop", bus.busy, 0);
        check_val("done_after_stop", bus.done, 0);
        check_val("pulse_after_stop", bus.pulse_out, 0);
        break;
      end
      check_val($sformatf("busy_k%0d", k), bus.busy, 1);
      check_val($sformatf("done_k%0d", k), bus.done, 0);
      check_val($sformatf("pulse_k%0d", k), bus.pulse_out, exp_pulse(k));
    end
    tick();
    if (stopped) begin
      check_val("no_done_stop", bus.done, 0);
      check_val("idle_stop", bus.busy, 0);
    end else begin
      check_val("done_pulse", bus.done, 1);
      check_val("busy_in_done", bus.busy, 0);
      check_val("pulse_in_done", bus.pulse_out, 0);
      for (int c = 0; c < NCH; c++) exp_edge[c] = edges_for(exp_per[c]);
      tick();
      check_val("done_one_cycle", bus.done, 0);
      check_val("busy_after_done", bus.busy, 0);
    end
    check_edges();
  endtask

  initial begin
    rst            = 1'b1;
    bus.cfg_ch     = 3'd0;
    bus.cfg_period = '0;
    bus.cfg_we     = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      exp_per[c]  = 0;
      exp_edge[c] = 0;
    end
    tick();
    tick();
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_pulse", bus.pulse_out, 0);
    check_val("rst_edge", bus.edge_cnt, 0);
    rst = 1'b0;
    tick();

    // Directed periods on ch0..3, random on the rest.
    cfg_write(0, 4);
    cfg_write(1, 3);
    cfg_write(2, 1);
    cfg_write(3, 0);
    for (int c = 4; c < NCH; c++) cfg_write(c, int'($urandom_range(12, 0)));
    run_window(-1, 1'b0);

    // Abort at cycle 500: no done, counts keep previous window's values.
    run_window(500, 1'b0);

    // Config write and start while busy are both ignored.
    run_window(-1, 1'b1);

    // Start and stop together in IDLE: no window.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_val("start_stop_busy", bus.busy, 0);
    tick();
    check_val("start_stop_busy2", bus.busy, 0);
    check_val("start_stop_done", bus.done, 0);

    // Randomized windows.
    for (int it = 0; it < 3; it++) begin
      int stop_at;
      for (int c = 0; c < NCH; c++) cfg_write(c, int'($urandom_range(15, 0)));
      stop_at = ($urandom_range(2, 0) == 0) ? int'($urandom_range(W - 2, 0)) : -1;
      run_window(stop_at, 1'b0);
    end

    // Asynchronous reset in the middle of a window.
    cfg_write(0, 4);
    bus.cfg_ch = 3'd0;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int k = 0; k < 200; k++) tick();
    #3;
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy", bus.busy, 0);
    check_val("mid_rst_done", bus.done, 0);
    check_val("mid_rst_pulse", bus.pulse_out, 0);
    check_val("mid_rst_edge", bus.edge_cnt, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      exp_per[c]  = 0;
      exp_edge[c] = 0;
    end
    tick();
    run_window(-1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sig_gen

// File: doc/sig_gen.md
SIG_GEN -- requirements
Module: sig_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of generated channels (channel order: sysclk, read, write, pawr, pard, refresh, cpuclk, romsel).
REQ-002 SHALL have parameter WIN_CYCLES, default 96000000, length of one generation window in clk cycles.
REQ-003 SHALL have parameter CNT_W, default 32, width of period and edge-count values.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cfg_ch  input  3  channel select for cfg_we and edge_cnt.
REQ-007 cfg_period  input  CNT_W  period in clk cycles for the selected channel.
REQ-008 cfg_we  input  1  write cfg_period into period register of cfg_ch.
REQ-009 start  input  1  single-cycle request to begin a window.
REQ-010 stop  input  1  single-cycle request to abort a window.
REQ-011 busy  output  1  high while a window runs.
REQ-012 done  output  1  one-cycle pulse when a window completes normally.
REQ-013 pulse_out  output  NUM_CH  generated signal per channel.
REQ-014 edge_cnt  output  CNT_W  rising edges emitted on channel cfg_ch during the last completed window.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when window counter equals WIN_CYCLES-1, RUN->IDLE on stop, DONE->IDLE unconditionally next cycle.
REQ-016 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-017 On IDLE->RUN, window counter and all channel phase counters SHALL clear to 0.
REQ-018 Per channel with period P>=2: phase counts 0..P-1 and wraps; registered output SHALL be high when phase < P>>1, low otherwise, one cycle latency from phase.
REQ-019 Channel with P<2 SHALL hold pulse_out low.
REQ-020 pulse_out SHALL be all-zero in IDLE and DONE.
REQ-021 cfg_we SHALL update period only in IDLE; cfg_we while busy SHALL be ignored.
REQ-022 start while busy SHALL be ignored; start and stop same cycle in IDLE: stop wins, no window.
REQ-023 stop in RUN SHALL return to IDLE next cycle, no done pulse, edge_cnt values unchanged.
REQ-024 Per channel, rising edges of pulse_out during RUN SHALL be counted; count latched into the readable register on RUN->DONE, equal to ceil(WIN_CYCLES/P) for P>=2, 0 for P<2.
REQ-025 edge_cnt SHALL be combinational mux of latched counts by cfg_ch; cfg_ch >= NUM_CH yields 0.
REQ-026 Counters SHALL be CNT_W bits, unsigned, no saturation needed (WIN_CYCLES < 2^CNT_W).

Reset
REQ-027 rst SHALL force IDLE, busy=0, done=0, pulse_out=0, all period registers=0, all phase/window/edge counters=0, latched counts=0, regardless of state.

Configuration
REQ-028 With SIG_GEN_EDGECNT_EN defined, edge counters and latches of REQ-024/025 SHALL be built; without it, edge_cnt SHALL be constant 0 and no counter logic synthesized; all other behaviour identical.

Structure
REQ-029 Package sig_gen_pkg SHALL hold the state enum and default constants NUM_CH, WIN_CYCLES, CNT_W.
REQ-030 Sub-module sig_gen_chan SHALL implement one channel (period register, phase counter, output register, edge counter); sig_gen instantiates NUM_CH of them plus the window FSM.

Verification (WIN_CYCLES=1000)
REQ-031 Ch0 P=4, start -> pulse_out[0] pattern 1,1,0,0 repeating from cycle after RUN entry; done at cycle 1000; edge_cnt(ch0)=250.
REQ-032 Ch1 P=3, ch2 P=1, ch3 P=0 -> edge_cnt 334, 0, 0; pulse_out[2], pulse_out[3] stay low.
REQ-033 stop at cycle 500 of a P=4 window -> busy falls next cycle, no done, edge_cnt keeps previous window's value.
REQ-034 cfg_we P=10 on ch0 while busy -> ignored; next window still yields 250.
REQ-035 rst asserted mid-window -> all outputs 0 immediately, periods 0, subsequent start produces no pulses.
REQ-036 start and stop same cycle in IDLE -> busy stays 0; start during RUN -> window length unchanged, done at cycle 1000.
